// File: rtl/neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_layer_sequencer
//
// Sequences one shared neuron instance across OUT_SIZE output neurons of a
// layer. For each neuron it presents the neuron/weight row index, fires a
// single-cycle start pulse, waits for the neuron to report done, then
// quantizes the signed accumulator (arithmetic shift, optional ReLU,
// saturation) into that neuron's slot of the packed activation vector.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   layer_go       layer start request, only honoured while idle
//   neuron_go      one-cycle start pulse to the neuron
//   neuron_done    neuron result valid this cycle
//   neuron_result  signed neuron accumulator, valid with neuron_done
//   neuron_sel     index of the neuron/weight row being computed
//   layer_out      packed activations, slot k at [(k+1)*WIDTH_Q-1 : k*WIDTH_Q]
//   busy           high from layer_go acceptance through the final DONE cycle
//   layer_done     one-cycle pulse once every slot has been written
// -----------------------------------------------------------------------------
module neuron_layer_sequencer #(
    parameter int OUT_SIZE  = 32,
    parameter int WIDTH_ACC = 32,
    parameter int WIDTH_Q   = 8,
    parameter int SHIFT     = 8,
    parameter int RELU      = 1,
    localparam int SEL_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        layer_go,
    output logic                        neuron_go,
    input  logic                        neuron_done,
    input  logic [WIDTH_ACC-1:0]        neuron_result,
    output logic [SEL_W-1:0]            neuron_sel,
    output logic [WIDTH_Q*OUT_SIZE-1:0] layer_out,
    output logic                        busy,
    output logic                        layer_done
);

    // Index of the final neuron; reaching it ends the issue/wait loop.
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(OUT_SIZE - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(0);

    localparam bit RELU_EN = (RELU != 32'sd0);

    // Saturation thresholds, built at 64 bits then narrowed to the
    // accumulator width so all comparisons happen at full WIDTH_ACC.
    localparam logic signed [63:0] U_MAX_L = (64'sd1 <<< WIDTH_Q) - 64'sd1;
    localparam logic signed [63:0] S_MAX_L = (64'sd1 <<< (WIDTH_Q - 1)) - 64'sd1;
    localparam logic signed [63:0] S_MIN_L = -(64'sd1 <<< (WIDTH_Q - 1));

    localparam logic signed [WIDTH_ACC-1:0] U_MAX = U_MAX_L[WIDTH_ACC-1:0];
    localparam logic signed [WIDTH_ACC-1:0] S_MAX = S_MAX_L[WIDTH_ACC-1:0];
    localparam logic signed [WIDTH_ACC-1:0] S_MIN = S_MIN_L[WIDTH_ACC-1:0];

    // Clamp codes in the quantized domain.
    localparam logic [WIDTH_Q-1:0] Q_ZERO = {WIDTH_Q{1'b0}};
    localparam logic [WIDTH_Q-1:0] Q_UMAX = {WIDTH_Q{1'b1}};
    localparam logic [WIDTH_Q-1:0] Q_SMAX = {1'b0, {(WIDTH_Q - 1){1'b1}}};
    localparam logic [WIDTH_Q-1:0] Q_SMIN = {1'b1, {(WIDTH_Q - 1){1'b0}}};

    localparam logic [WIDTH_Q*OUT_SIZE-1:0] OUT_ZERO = {(WIDTH_Q * OUT_SIZE){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_STORE_LAST = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t                      state_r;
    logic                        neuron_go_r;
    logic [SEL_W-1:0]            neuron_sel_r;
    logic [WIDTH_Q*OUT_SIZE-1:0] layer_out_r;
    logic                        busy_r;
    logic                        layer_done_r;
    logic [WIDTH_Q-1:0]          q_s;

    // Floor shift (no rounding), then clamp to the unsigned range with
    // negatives zeroed (ReLU) or to the signed two's-complement range.
    function automatic logic [WIDTH_Q-1:0] quantize(input logic signed [WIDTH_ACC-1:0] x);
        logic signed [WIDTH_ACC-1:0] s;
        logic [WIDTH_Q-1:0]          q;
        s = x >>> SHIFT;
        if (RELU_EN) begin
            if (s[WIDTH_ACC-1]) begin
                q = Q_ZERO;
            end else if (s > U_MAX) begin
                q = Q_UMAX;
            end else begin
                q = s[WIDTH_Q-1:0];
            end
        end else begin
            if (s < S_MIN) begin
                q = Q_SMIN;
            end else if (s > S_MAX) begin
                q = Q_SMAX;
            end else begin
                q = s[WIDTH_Q-1:0];
            end
        end
        return q;
    endfunction

    // Quantized view of the current neuron result.
    always_comb begin
        q_s = quantize($signed(neuron_result));
    end

    // Layer sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            neuron_go_r  <= 1'b0;
            neuron_sel_r <= SEL_ZERO;
            layer_out_r  <= OUT_ZERO;
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    layer_done_r <= 1'b0;
                    if (layer_go) begin
                        // Start pulse is registered so it is high during ISSUE.
                        state_r      <= ST_ISSUE;
                        neuron_go_r  <= 1'b1;
                        neuron_sel_r <= SEL_ZERO;
                        layer_out_r  <= OUT_ZERO;
                        busy_r       <= 1'b1;
                    end else begin
                        neuron_go_r  <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    neuron_go_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (neuron_done) begin
                        for (int k = 0; k < OUT_SIZE; k++) begin
                            if (neuron_sel_r == SEL_W'(k)) begin
                                layer_out_r[k*WIDTH_Q +: WIDTH_Q] <= q_s;
                            end
                        end
                        if (neuron_sel_r == LAST_SEL) begin
                            state_r <= ST_STORE_LAST;
                        end else begin
                            // Next neuron is issued straight away; the neuron
                            // has just returned to idle after reporting done.
                            neuron_sel_r <= neuron_sel_r + SEL_ONE;
                            neuron_go_r  <= 1'b1;
                            state_r      <= ST_ISSUE;
                        end
                    end
                end

                ST_STORE_LAST: begin
                    // Final slot has been written; flag completion next cycle.
                    layer_done_r <= 1'b1;
                    state_r      <= ST_DONE;
                end

                ST_DONE: begin
                    layer_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end

                default: begin
                    state_r      <= ST_IDLE;
                    neuron_go_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    layer_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign neuron_go  = neuron_go_r;
    assign neuron_sel = neuron_sel_r;
    assign layer_out  = layer_out_r;
    assign busy       = busy_r;
    assign layer_done = layer_done_r;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for neuron_layer_sequencer. Three instances share one
// neuron stub: A (OUT_SIZE=4, ReLU), B (OUT_SIZE=4, signed saturation) and
// C (OUT_SIZE=1). Only one instance runs at a time; idle instances see the
// stub's done pulses and must ignore them.
// -----------------------------------------------------------------------------
module tb_neuron_layer_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go_a = 1'b0;
    logic go_b = 1'b0;
    logic go_c = 1'b0;
    logic neuron_done = 1'b0;
    logic [31:0] neuron_result = 32'h0;

    logic        ng_a, busy_a, ld_a;
    logic [1:0]  sel_a;
    logic [31:0] lo_a;
    logic        ng_b, busy_b, ld_b;
    logic [1:0]  sel_b;
    logic [31:0] lo_b;
    logic        ng_c, busy_c, ld_c;
    logic [0:0]  sel_c;
    logic [7:0]  lo_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    neuron_layer_sequencer #(.OUT_SIZE(4), .WIDTH_ACC(32), .WIDTH_Q(8), .SHIFT(8), .RELU(1)) u_a (
        .clk(clk), .reset(reset), .layer_go(go_a), .neuron_go(ng_a), .neuron_done(neuron_done),
        .neuron_result(neuron_result), .neuron_sel(sel_a), .layer_out(lo_a), .busy(busy_a),
        .layer_done(ld_a));

    neuron_layer_sequencer #(.OUT_SIZE(4), .WIDTH_ACC(32), .WIDTH_Q(8), .SHIFT(8), .RELU(0)) u_b (
        .clk(clk), .reset(reset), .layer_go(go_b), .neuron_go(ng_b), .neuron_done(neuron_done),
        .neuron_result(neuron_result), .neuron_sel(sel_b), .layer_out(lo_b), .busy(busy_b),
        .layer_done(ld_b));

    neuron_layer_sequencer #(.OUT_SIZE(1), .WIDTH_ACC(32), .WIDTH_Q(8), .SHIFT(8), .RELU(1)) u_c (
        .clk(clk), .reset(reset), .layer_go(go_c), .neuron_go(ng_c), .neuron_done(neuron_done),
        .neuron_result(neuron_result), .neuron_sel(sel_c), .layer_out(lo_c), .busy(busy_c),
        .layer_done(ld_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Neuron stub: done is high exactly stub_d cycles after the go cycle,
    // returning the table entry for the row selected at go time.
    int          stub_d     = 3;
    int          stub_cnt   = 0;
    int          stub_idx   = 0;
    bit          spur_idle  = 1'b0;
    bit          spur_issue = 1'b0;
    logic [31:0] res_tab [0:3];

    always @(negedge clk) begin
        if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                neuron_done   = 1'b1;
                neuron_result = res_tab[stub_idx];
            end else begin
                neuron_done = 1'b0;
            end
        end else if (spur_idle) begin
            neuron_done   = 1'b1;
            neuron_result = 32'h7FFF_FFFF;
        end else begin
            neuron_done = 1'b0;
        end
        if (ng_a || ng_b || ng_c) begin
            stub_idx = ng_a ? int'(sel_a) : (ng_b ? int'(sel_b) : 0);
            stub_cnt = stub_d;
            if (spur_issue && stub_idx == 0) begin
                neuron_done   = 1'b1;
                neuron_result = 32'h7FFF_FFFF;
            end
        end
    end

    // Monitor: monotonic event counters and a log of neuron_sel per go pulse.
    int   go_cnt_a = 0, go_dbl_a = 0, go_cnt_b = 0, go_cnt_c = 0;
    int   ld_cnt_a = 0, ld_cnt_b = 0, ld_cnt_c = 0;
    logic go_a_prev = 1'b0;
    int   sel_log [0:15];

    always @(negedge clk) begin
        if (ng_a) begin
            sel_log[go_cnt_a % 16] = int'(sel_a);
            go_cnt_a = go_cnt_a + 1;
            if (go_a_prev) go_dbl_a = go_dbl_a + 1;
        end
        go_a_prev = ng_a;
        if (ng_b) go_cnt_b = go_cnt_b + 1;
        if (ng_c) go_cnt_c = go_cnt_c + 1;
        if (ld_a) ld_cnt_a = ld_cnt_a + 1;
        if (ld_b) ld_cnt_b = ld_cnt_b + 1;
        if (ld_c) ld_cnt_c = ld_cnt_c + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Pulse layer_go on one instance and wait (bounded) for its layer_done.
    // lat = cycles from the layer_go sampling cycle to the DONE cycle.
    task automatic start_and_wait(input int which, output int lat, output bit ok);
        int   c0;
        logic seen;
        c0 = cyc;
        case (which)
            0:       go_a = 1'b1;
            1:       go_b = 1'b1;
            default: go_c = 1'b1;
        endcase
        step();
        go_a = 1'b0;
        go_b = 1'b0;
        go_c = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            seen = (which == 0) ? ld_a : ((which == 1) ? ld_b : ld_c);
            if (seen) begin
                ok  = 1'b1;
                lat = cyc - c0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        n_tests++;
        if ({ng_a, sel_a, lo_a, busy_a, ld_a} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_a: go=%b sel=%0d out=%h busy=%b done=%b, want all 0", ng_a, sel_a, lo_a, busy_a, ld_a);
        end
        n_tests++;
        if ({ng_b, sel_b, lo_b, busy_b, ld_b} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_b: go=%b sel=%0d out=%h busy=%b done=%b, want all 0", ng_b, sel_b, lo_b, busy_b, ld_b);
        end
        n_tests++;
        if ({ng_c, sel_c, lo_c, busy_c, ld_c} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_c: go=%b sel=%0d out=%h busy=%b done=%b, want all 0", ng_c, sel_c, lo_c, busy_c, ld_c);
        end
    endtask

    task automatic test_nominal();
        int g0, d0, dbl0, lat;
        bit ok, sel_ok;
        res_tab = '{32'h0000_0500, 32'hFFFF_F000, 32'h0001_0000, 32'h0000_01FF};
        stub_d = 3;
        g0 = go_cnt_a; d0 = ld_cnt_a; dbl0 = go_dbl_a;
        start_and_wait(0, lat, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL nominal_timeout: no layer_done within 200 cycles"); end
        n_tests++;
        if (lat != 18) begin n_fail++; $display("FAIL nominal_latency: got %0d want 18", lat); end
        n_tests++;
        if (lo_a !== 32'h01FF_0005) begin n_fail++; $display("FAIL nominal_out: got %h want 01ff0005", lo_a); end
        n_tests++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL nominal_busy_done: got %b want 1", busy_a); end
        n_tests++;
        if (go_cnt_a - g0 != 4) begin n_fail++; $display("FAIL nominal_go_count: got %0d want 4", go_cnt_a - g0); end
        sel_ok = 1'b1;
        for (int i = 0; i < 4; i++) if (sel_log[(g0 + i) % 16] != i) sel_ok = 1'b0;
        n_tests++;
        if (!sel_ok) begin
            n_fail++;
            $display("FAIL nominal_sel_seq: got %0d,%0d,%0d,%0d want 0,1,2,3", sel_log[g0 % 16],
                     sel_log[(g0 + 1) % 16], sel_log[(g0 + 2) % 16], sel_log[(g0 + 3) % 16]);
        end
        n_tests++;
        if (go_dbl_a != dbl0) begin n_fail++; $display("FAIL nominal_go_width: got %0d multi-cycle pulses want 0", go_dbl_a - dbl0); end
        step();
        n_tests++;
        if ({busy_a, ld_a, ng_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL nominal_idle: busy/done/go got %b%b%b want 000", busy_a, ld_a, ng_a);
        end
        repeat (5) step();
        n_tests++;
        if (ld_cnt_a - d0 != 1) begin n_fail++; $display("FAIL nominal_done_count: got %0d want 1", ld_cnt_a - d0); end
        n_tests++;
        if (lo_a !== 32'h01FF_0005) begin n_fail++; $display("FAIL nominal_hold: got %h want 01ff0005", lo_a); end
    endtask

    task automatic test_reset_abort();
        int g0, d0, lat;
        bit ok, reached;
        g0 = go_cnt_a; d0 = ld_cnt_a;
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (go_cnt_a - g0 >= 3) begin reached = 1'b1; break; end
            step();
        end
        n_tests++;
        if (!reached) begin n_fail++; $display("FAIL abort_reach_slot2: got %0d go pulses want 3", go_cnt_a - g0); end
        step();
        n_tests++;
        if (lo_a !== 32'h0000_0005) begin n_fail++; $display("FAIL abort_partial: got %h want 00000005", lo_a); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if ({ng_a, sel_a, lo_a, busy_a, ld_a} !== 37'd0) begin
            n_fail++;
            $display("FAIL abort_reset_vals: go=%b sel=%0d out=%h busy=%b done=%b want all 0", ng_a, sel_a, lo_a, busy_a, ld_a);
        end
        repeat (25) step();
        n_tests++;
        if (ld_cnt_a != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", ld_cnt_a - d0); end
        start_and_wait(0, lat, ok);
        n_tests++;
        if (!ok || lat != 18) begin n_fail++; $display("FAIL abort_rerun_latency: got ok=%b lat=%0d want 1,18", ok, lat); end
        n_tests++;
        if (lo_a !== 32'h01FF_0005) begin n_fail++; $display("FAIL abort_rerun_out: got %h want 01ff0005", lo_a); end
        step();
    endtask

    task automatic test_back_to_back();
        int c0, t1, t2, d0, g_end;
        bit ok;
        d0 = ld_cnt_a;
        c0 = cyc;
        go_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ld_a) begin ok = 1'b1; break; end
            step();
        end
        t1 = cyc;
        n_tests++;
        if (!ok || t1 - c0 != 18) begin n_fail++; $display("FAIL b2b_first: got ok=%b lat=%0d want 1,18", ok, t1 - c0); end
        step();
        n_tests++;
        if ({busy_a, ng_a, ld_a} !== 3'b000 || lo_a !== 32'h01FF_0005) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy/go/done=%b%b%b out=%h want 000 01ff0005", busy_a, ng_a, ld_a, lo_a);
        end
        step();
        go_a = 1'b0;
        n_tests++;
        if (ng_a !== 1'b1 || sel_a !== 2'd0 || lo_a !== 32'h0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_issue: go=%b sel=%0d out=%h busy=%b want 1 0 00000000 1", ng_a, sel_a, lo_a, busy_a);
        end
        step();
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ld_a) begin ok = 1'b1; break; end
            step();
        end
        t2 = cyc;
        n_tests++;
        if (!ok || t2 - t1 != 19) begin n_fail++; $display("FAIL b2b_second: got ok=%b gap=%0d want 1,19", ok, t2 - t1); end
        g_end = go_cnt_a;
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        repeat (6) step();
        n_tests++;
        if (go_cnt_a != g_end || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_go_in_done: got %0d new go pulses busy=%b want 0,0", go_cnt_a - g_end, busy_a);
        end
        n_tests++;
        if (ld_cnt_a - d0 != 2 || lo_a !== 32'h01FF_0005) begin
            n_fail++;
            $display("FAIL b2b_end: done pulses=%0d out=%h want 2 01ff0005", ld_cnt_a - d0, lo_a);
        end
    endtask

    task automatic test_relu0();
        int g0, lat;
        bit ok;
        res_tab = '{32'hFFFF_FD00, 32'hFFF0_0000, 32'h0000_7FFF, 32'h0000_0000};
        stub_d = 3;
        g0 = go_cnt_b;
        start_and_wait(1, lat, ok);
        n_tests++;
        if (!ok || lat != 18) begin n_fail++; $display("FAIL relu0_latency: got ok=%b lat=%0d want 1,18", ok, lat); end
        n_tests++;
        if (lo_b !== 32'h007F_80FD) begin n_fail++; $display("FAIL relu0_out: got %h want 007f80fd", lo_b); end
        n_tests++;
        if (go_cnt_b - g0 != 4) begin n_fail++; $display("FAIL relu0_go_count: got %0d want 4", go_cnt_b - g0); end
        repeat (3) step();
    endtask

    task automatic test_single();
        int g0, lat;
        bit ok;
        res_tab = '{32'h0000_1234, 32'h0, 32'h0, 32'h0};
        stub_d = 3;
        g0 = go_cnt_c;
        start_and_wait(2, lat, ok);
        n_tests++;
        if (!ok || lat != 6) begin n_fail++; $display("FAIL single_latency: got ok=%b lat=%0d want 1,6", ok, lat); end
        n_tests++;
        if (lo_c !== 8'h12) begin n_fail++; $display("FAIL single_out: got %h want 12", lo_c); end
        n_tests++;
        if (go_cnt_c - g0 != 1) begin n_fail++; $display("FAIL single_go_count: got %0d want 1", go_cnt_c - g0); end
        repeat (3) step();
    endtask

    task automatic test_spurious();
        int d0, lat;
        bit ok;
        d0 = ld_cnt_a;
        spur_idle = 1'b1;
        repeat (3) step();
        spur_idle = 1'b0;
        repeat (2) step();
        n_tests++;
        if (lo_a !== 32'h01FF_0005 || busy_a !== 1'b0 || ld_cnt_a != d0) begin
            n_fail++;
            $display("FAIL spur_idle: out=%h busy=%b done pulses=%0d want 01ff0005 0 0", lo_a, busy_a, ld_cnt_a - d0);
        end
        res_tab = '{32'h0000_0500, 32'hFFFF_F000, 32'h0001_0000, 32'h0000_01FF};
        stub_d = 3;
        spur_issue = 1'b1;
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        step();
        spur_issue = 1'b0;
        n_tests++;
        if (lo_a !== 32'h0) begin n_fail++; $display("FAIL spur_issue_write: got %h want 00000000", lo_a); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ld_a) begin ok = 1'b1; break; end
            step();
        end
        n_tests++;
        if (!ok || lo_a !== 32'h01FF_0005) begin n_fail++; $display("FAIL spur_issue_run: ok=%b out=%h want 1 01ff0005", ok, lo_a); end
        repeat (3) step();
        res_tab = '{32'h0000_0100, 32'h0000_2A00, 32'h8000_0000, 32'h0000_FF80};
        stub_d = 1;
        start_and_wait(0, lat, ok);
        n_tests++;
        if (!ok || lat != 10) begin n_fail++; $display("FAIL d1_latency: got ok=%b lat=%0d want 1,10", ok, lat); end
        n_tests++;
        if (lo_a !== 32'hFF00_2A01) begin n_fail++; $display("FAIL d1_out: got %h want ff002a01", lo_a); end
        repeat (3) step();
        n_tests++;
        if (lo_b !== 32'h007F_80FD || lo_c !== 8'h12 || ld_cnt_b != 1 || ld_cnt_c != 1) begin
            n_fail++;
            $display("FAIL idle_instances_hold: b=%h c=%h done_b=%0d done_c=%0d want 007f80fd 12 1 1", lo_b, lo_c, ld_cnt_b, ld_cnt_c);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reset_abort();
        test_back_to_back();
        test_relu0();
        test_single();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Initiator side of the neuron go/done handshake. Drives one shared neuron instance serially across OUT_SIZE output neurons.
- Per neuron: drives the neuron/weight select index, issues a one-cycle start pulse, waits for done, then captures the signed accumulator result.
- Each result goes through ReLU, shift and saturation, and is packed into a flattened activation vector that the next layer uses as its input data.
- Sits between the layer-level control FSM and the neuron/weight-ROM datapath.

Parameters:
- OUT_SIZE, 32, number of neurons in the layer (≥1).
- WIDTH_ACC, 32, width of the signed neuron result.
- WIDTH_Q, 8, width of each quantized activation.
- SHIFT, 8, arithmetic right shift applied before saturation (0 ≤ SHIFT < WIDTH_ACC).
- RELU, 1. 1 = ReLU plus unsigned saturation; 0 = signed saturation, no ReLU.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- layer_go  in  1  start request; sampled only in IDLE.
- neuron_go  out  1  one-cycle start pulse to the neuron.
- neuron_done  in  1  neuron result valid this cycle.
- neuron_result  in  WIDTH_ACC  signed neuron output, valid when neuron_done=1.
- neuron_sel  out  $clog2(OUT_SIZE) (min 1)  index of the neuron/weight row being computed.
- layer_out  out  WIDTH_Q*OUT_SIZE  packed activations; slot k = bits [(k+1)*WIDTH_Q-1 : k*WIDTH_Q].
- busy  out  1  high from layer_go acceptance through the DONE state.
- layer_done  out  1  one-cycle pulse when all OUT_SIZE slots are written.

Behaviour:
- Reset values: state=IDLE, neuron_go=0, neuron_sel=0, layer_out=0, busy=0, layer_done=0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, STORE_LAST, DONE.
- IDLE:
  - layer_go=1 → ISSUE.
  - On that same edge: neuron_sel←0, layer_out←0, busy←1.
- ISSUE:
  - neuron_go=1 for exactly this cycle; neuron_sel stable.
  - Unconditionally → WAIT.
- WAIT:
  - neuron_go=0.
  - On neuron_done=1: slot[neuron_sel]←Q(neuron_result).
  - If neuron_sel==OUT_SIZE-1 → STORE_LAST; else neuron_sel←neuron_sel+1 and → ISSUE.
  - neuron_done=0 → stay in WAIT. No timeout.
- STORE_LAST: one cycle, lets the final slot settle. → DONE.
- DONE: layer_done=1, busy=1 for this cycle only. → IDLE.
- Quantization Q(x):
  - s = x >>> SHIFT (arithmetic shift, floor, no rounding).
  - RELU=1: s<0 → 0; s>2^WIDTH_Q-1 → 2^WIDTH_Q-1; else s[WIDTH_Q-1:0].
  - RELU=0: clamp to [-2^(WIDTH_Q-1), 2^(WIDTH_Q-1)-1], two's complement.
  - Comparisons are done at full WIDTH_ACC width.
- Timing:
  - ISSUE directly follows a done cycle, so the next neuron_go always lands while the neuron has returned to IDLE.
  - Per-neuron period = 1 + D cycles, where D = cycles spent in WAIT (D≥1).
  - Layer latency, from the layer_go sampling edge to layer_done high = OUT_SIZE*(1+D) + 2 cycles.
- Boundary and concurrency rules:
  - layer_go is ignored in every state except IDLE, including DONE. Holding layer_go high gives back-to-back layers with exactly one IDLE cycle between them.
  - neuron_done outside WAIT is ignored and writes nothing.
  - neuron_result is sampled only in a WAIT cycle with neuron_done=1.
  - Slots not yet written in the current layer read 0.
  - reset at any cycle aborts immediately to the reset values. No layer_done is issued for an aborted layer.
  - OUT_SIZE=1 is legal: ISSUE, WAIT, STORE_LAST, DONE.
  - layer_out holds its value after DONE until the next layer_go acceptance.

Test Plan:
(Default params except OUT_SIZE=4; stub neuron asserts done 3 cycles after go.)
1. Nominal run, results 0x00000500, 0xFFFFF000, 0x00010000, 0x000001FF → layer_out=0x01FF0005. Check: neuron_go pulses exactly 4 times with neuron_sel 0,1,2,3; one layer_done pulse at latency 4*(1+3)+2=18 cycles.
2. RELU=0, results 0xFFFFFD00, 0xFFF00000, 0x00007FFF, 0x00000000 → slots 0xFD, 0x80, 0x7F, 0x00 (layer_out=0x007F80FD).
3. reset asserted in WAIT for slot 2 → next cycle all outputs 0, busy=0, no layer_done. A following layer_go completes a full run with correct values.
4. layer_go held high for two layers → one IDLE cycle between DONE and the next ISSUE; layer_out cleared at the second start. layer_go pulsed while busy → no effect.
5. Spurious neuron_done in IDLE and ISSUE → no slot written. Stub with D=1 (done the cycle after go) → correct packing; latency 4*2+2=10.
6. OUT_SIZE=1, result 0x00001234 → layer_out=0x12, layer_done after 1+3+2=6 cycles.
